// File: rtl/breath_seq.sv
// Breathing-brightness duty sequencer for the PWM LED path.
// Ramps duty up, dwells at full scale, ramps down, dwells at zero, on a
// prescaled tick; pause via en, step size via speed.
module breath_seq #(
   parameter int unsigned BITS       = 9,
   parameter int unsigned TICK_DIV   = 12000,
   parameter int unsigned HOLD_TICKS = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [1:0]      speed,
   output logic [BITS-1:0] duty,
   output logic            duty_upd,
   output logic            dir,
   output logic            cycle_done
);

   localparam int unsigned CntW    = $clog2(TICK_DIV);
   localparam int unsigned HoldW   = (HOLD_TICKS < 2) ? 1 : $clog2(HOLD_TICKS);
   localparam logic [CntW-1:0]  CntLast  = CntW'(TICK_DIV - 1);
   localparam logic [HoldW-1:0] HoldLast = HoldW'((HOLD_TICKS == 0) ? 0 : HOLD_TICKS - 1);
   localparam logic [BITS:0]    MaxV     = {1'b0, {BITS{1'b1}}};
   localparam logic [BITS-1:0]  DutyMax  = '1;

   typedef enum logic [2:0] {StIdle, StRise, StHoldHi, StFall, StHoldLo} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [HoldW-1:0] hold_q, hold_d;
   logic [BITS-1:0] duty_q, duty_d;
   logic            upd_q, upd_d;
   logic            dir_q, dir_d;
   logic            cd_q, cd_d;
   logic            tick;

   logic [BITS:0]   step_w, sum_w, diff_w;
   logic [BITS-1:0] rise_val, fall_val;

   // Prescaler: free-runs while enabled, cleared while paused.
   always_comb begin
      tick  = en && (cnt_q == CntLast);
      cnt_d = (!en || tick) ? '0 : cnt_q + CntW'(1);
   end

   // Saturating ramp arithmetic, one bit wider than duty so nothing wraps.
   always_comb begin
      step_w   = {{BITS{1'b0}}, 1'b1} << speed;
      sum_w    = {1'b0, duty_q} + step_w;
      diff_w   = {1'b0, duty_q} - step_w;
      rise_val = (sum_w > MaxV) ? DutyMax : sum_w[BITS-1:0];
      fall_val = ({1'b0, duty_q} <= step_w) ? '0 : diff_w[BITS-1:0];
   end

   // Next state, duty, dwell count and registered-output values.
   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      hold_d  = hold_q;
      cd_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (en) state_d = StRise;
         end
         StRise: begin
            if (tick) begin
               duty_d = rise_val;
               if (rise_val == DutyMax) state_d = (HOLD_TICKS != 0) ? StHoldHi : StFall;
            end
         end
         StHoldHi, StHoldLo: begin
            if (tick) begin
               if (hold_q == HoldLast) begin
                  hold_d  = '0;
                  state_d = (state_q == StHoldHi) ? StFall : StRise;
               end else begin
                  hold_d = hold_q + HoldW'(1);
               end
            end
         end
         StFall: begin
            if (tick) begin
               duty_d = fall_val;
               if (fall_val == '0) begin
                  cd_d    = 1'b1;
                  state_d = (HOLD_TICKS != 0) ? StHoldLo : StRise;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      upd_d = (duty_d != duty_q);
      dir_d = (state_d == StRise) || (state_d == StHoldHi);
   end

   // State and output registers; reset clears everything at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         hold_q  <= '0;
         duty_q  <= '0;
         upd_q   <= 1'b0;
         dir_q   <= 1'b0;
         cd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         duty_q  <= duty_d;
         upd_q   <= upd_d;
         dir_q   <= dir_d;
         cd_q    <= cd_d;
      end
   end

   assign duty       = duty_q;
   assign duty_upd   = upd_q;
   assign dir        = dir_q;
   assign cycle_done = cd_q;

endmodule

// File: tb/tb_breath_seq.sv
// Scoreboard bench for breath_seq: two instances (dwell 2 and dwell 0) share
// randomized en/speed stimulus; a reference model predicts each output event
// with its cycle stamp and a monitor matches what the DUTs present.
module tb_breath_seq;

   localparam int BITS   = 4;
   localparam int TDIV   = 4;
   localparam int HOLD_A = 2;
   localparam int HOLD_B = 0;
   localparam int MAXV   = (1 << BITS) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b1;
   logic [1:0] speed = 2'd0;
   logic [BITS-1:0] duty_a, duty_b;
   logic upd_a, upd_b, dir_a, dir_b, cd_a, cd_b;

   breath_seq #(.BITS(BITS), .TICK_DIV(TDIV), .HOLD_TICKS(HOLD_A)) u_dut_a (
      .clk(clk), .rst(rst), .en(en), .speed(speed),
      .duty(duty_a), .duty_upd(upd_a), .dir(dir_a), .cycle_done(cd_a)
   );

   breath_seq #(.BITS(BITS), .TICK_DIV(TDIV), .HOLD_TICKS(HOLD_B)) u_dut_b (
      .clk(clk), .rst(rst), .en(en), .speed(speed),
      .duty(duty_b), .duty_upd(upd_b), .dir(dir_b), .cycle_done(cd_b)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      int              cyc;
      logic [BITS-1:0] duty;
      logic            dir;
      logic            upd;
      logic            cd;
   } ev_t;

   ev_t q0[$];
   ev_t q1[$];

   // Reference model: phase 0 idle, 1 rising, 2 top dwell, 3 falling, 4 bottom dwell.
   int m_ph[2];
   int m_duty[2];
   int m_hc[2];
   int m_cnt;

   function automatic bit up_phase(input int ph);
      return (ph == 1) || (ph == 2);
   endfunction

   function automatic int qsz(input int i);
      return (i == 0) ? q0.size() : q1.size();
   endfunction

   function automatic ev_t qfront(input int i);
      return (i == 0) ? q0[0] : q1[0];
   endfunction

   function automatic void qpop(input int i);
      if (i == 0) void'(q0.pop_front());
      else void'(q1.pop_front());
   endfunction

   function automatic void qpush(input int i, input ev_t e);
      if (i == 0) q0.push_back(e);
      else q1.push_back(e);
   endfunction

   // Predict what the coming posedge produces for both instances.
   task automatic model_edge();
      bit tick;
      int step_sz, hold, od, nd;
      bit odir, ndir, cd;
      ev_t e;
      tick = en && (m_cnt == TDIV - 1);
      m_cnt = (!en || tick) ? 0 : m_cnt + 1;
      step_sz = 1 << speed;
      for (int i = 0; i < 2; i++) begin
         hold = (i == 0) ? HOLD_A : HOLD_B;
         od   = m_duty[i];
         odir = up_phase(m_ph[i]);
         cd   = 1'b0;
         case (m_ph[i])
            0: if (en) m_ph[i] = 1;
            1: if (tick) begin
               m_duty[i] = (od + step_sz > MAXV) ? MAXV : od + step_sz;
               if (m_duty[i] == MAXV) m_ph[i] = (hold > 0) ? 2 : 3;
            end
            2, 4: if (tick) begin
               m_hc[i]++;
               if (m_hc[i] == hold) begin
                  m_hc[i] = 0;
                  m_ph[i] = (m_ph[i] == 2) ? 3 : 1;
               end
            end
            3: if (tick) begin
               m_duty[i] = (od - step_sz < 0) ? 0 : od - step_sz;
               if (m_duty[i] == 0) begin
                  cd = 1'b1;
                  m_ph[i] = (hold > 0) ? 4 : 1;
               end
            end
            default: m_ph[i] = 0;
         endcase
         nd   = m_duty[i];
         ndir = up_phase(m_ph[i]);
         if (nd != od || cd || ndir != odir) begin
            e.cyc  = cyc + 1;
            e.duty = BITS'(nd);
            e.dir  = ndir;
            e.upd  = (nd != od);
            e.cd   = cd;
            qpush(i, e);
         end
      end
   endtask

   // Model side of an asynchronous reset; a falling dir is still an event.
   task automatic model_reset();
      ev_t e;
      for (int i = 0; i < 2; i++) begin
         if (up_phase(m_ph[i])) begin
            e.cyc  = cyc + 1;
            e.duty = '0;
            e.dir  = 1'b0;
            e.upd  = 1'b0;
            e.cd   = 1'b0;
            qpush(i, e);
         end
         m_ph[i]   = 0;
         m_duty[i] = 0;
         m_hc[i]   = 0;
      end
      m_cnt = 0;
   endtask

   task automatic drive(input bit e, input bit [1:0] sp);
      en    = e;
      speed = sp;
      model_edge();
   endtask

   task automatic step(input bit e, input bit [1:0] sp);
      @(negedge clk);
      drive(e, sp);
   endtask

   task automatic check_zero(input string name);
      checks++;
      if ({duty_a, dir_a, upd_a, cd_a, duty_b, dir_b, upd_b, cd_b} !== '0) begin
         errors++;
         $display("FAIL %s: got a duty=%0d dir=%0d upd=%0d cd=%0d b duty=%0d dir=%0d upd=%0d cd=%0d, required all 0",
                  name, duty_a, dir_a, upd_a, cd_a, duty_b, dir_b, upd_b, cd_b);
      end
   endtask

   // Monitor body: retire overdue predictions, then match any presented event.
   task automatic mon(input int i, input logic [BITS-1:0] d, input logic dr, input logic up,
                      input logic cd, input logic pdir);
      ev_t e;
      while (qsz(i) > 0) begin
         e = qfront(i);
         if (e.cyc >= cyc) break;
         qpop(i);
         checks++;
         errors++;
         $display("FAIL missed_event[%0d]: got no event, required at cycle %0d duty=%0d dir=%0d upd=%0d cd=%0d",
                  i, e.cyc, e.duty, e.dir, e.upd, e.cd);
      end
      if (up || cd || dr != pdir) begin
         checks++;
         if (qsz(i) == 0) begin
            errors++;
            $display("FAIL unexpected_event[%0d]: cycle %0d got duty=%0d dir=%0d upd=%0d cd=%0d, required none",
                     i, cyc, d, dr, up, cd);
         end else begin
            e = qfront(i);
            if (e.cyc != cyc) begin
               errors++;
               $display("FAIL unexpected_event[%0d]: cycle %0d got duty=%0d dir=%0d upd=%0d cd=%0d, required none before cycle %0d",
                        i, cyc, d, dr, up, cd, e.cyc);
            end else begin
               qpop(i);
               if ({d, dr, up, cd} !== {e.duty, e.dir, e.upd, e.cd}) begin
                  errors++;
                  $display("FAIL event_value[%0d]: cycle %0d got duty=%0d dir=%0d upd=%0d cd=%0d, required duty=%0d dir=%0d upd=%0d cd=%0d",
                           i, cyc, d, dr, up, cd, e.duty, e.dir, e.upd, e.cd);
               end
            end
         end
      end
   endtask

   logic pdir_a = 1'b0;
   logic pdir_b = 1'b0;

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      mon(0, duty_a, dir_a, upd_a, cd_a, pdir_a);
      pdir_a = dir_a;
      mon(1, duty_b, dir_b, upd_b, cd_b, pdir_b);
      pdir_b = dir_b;
   end

   initial begin
      bit found;
      m_cnt = 0;
      for (int i = 0; i < 2; i++) begin
         m_ph[i] = 0;
         m_duty[i] = 0;
         m_hc[i] = 0;
      end

      // Reset held with en=1: nothing may move.
      repeat (3) begin
         @(negedge clk);
         check_zero("reset_with_en");
      end
      rst = 1'b0;
      drive(1'b1, 2'd0);

      // Full cycles at unit step (covers dwell and no-dwell periods).
      repeat (150) step(1'b1, 2'd0);
      // Largest step: saturation at both ends.
      repeat (100) step(1'b1, 2'd3);

      // Pause at duty 6 while rising.
      found = 1'b0;
      for (int k = 0; k < 300 && !found; k++) begin
         step(1'b1, 2'd0);
         if (m_ph[0] == 1 && m_duty[0] == 6) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL pause_setup: got no rise through duty 6 within bound, required one");
      end
      repeat (50) step(1'b0, 2'd0);
      repeat (20) step(1'b1, 2'd0);

      // Async reset while falling at duty 9, between clock edges.
      found = 1'b0;
      for (int k = 0; k < 300 && !found; k++) begin
         step(1'b1, 2'd0);
         if (m_ph[0] == 3 && m_duty[0] == 9) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL reset_setup: got no fall through duty 9 within bound, required one");
      end
      @(negedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      #1;
      check_zero("async_reset_immediate");
      @(negedge clk);
      @(negedge clk);
      check_zero("async_reset_held");
      rst = 1'b0;
      drive(1'b1, 2'd0);

      // Randomized segments of en/speed.
      for (int s = 0; s < 40; s++) begin
         bit e;
         bit [1:0] sp;
         int len;
         e   = ($urandom_range(0, 5) != 0);
         sp  = 2'($urandom_range(0, 3));
         len = $urandom_range(3, 40);
         for (int k = 0; k < len; k++) step(e, sp);
      end

      repeat (10) step(1'b1, 2'd1);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d/%0d pending predictions, required 0/0", q0.size(), q1.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
